nf_10g_tx_frame_buffer: RTL and testbench

//  Store-and-forward frame buffer on the 10G TX path, clk156 domain, between the TX async FIFO
//  (64b AXIS, may gap mid-frame) and the MAC s_axis_tx port. The MAC flags underrun on any
//  mid-frame tvalid gap, so a frame is released only once fully buffered and error-free.

---
 rtl/nf_10g_tx_frame_buffer.sv | 171 +++++++++++++++++
 tb/tb_nf_10g_tx_frame_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_10g_tx_frame_buffer.sv
// Store-and-forward TX frame buffer between the TX async FIFO and the 10G MAC (clk156 domain).
// Optional statistics counters are enabled by defining NF_10G_TX_BUF_STATS_EN.
module nf_10g_tx_frame_buffer #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_DEPTH_LOG2 = 9
) (
  input  logic                      clk156,
  input  logic                      areset_clk156,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tuser,
  output logic [C_DATA_WIDTH-1:0]   m_axis_mac_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_mac_tkeep,
  output logic                      m_axis_mac_tvalid,
  input  logic                      m_axis_mac_tready,
  output logic                      m_axis_mac_tlast,
  output logic                      m_axis_mac_tuser,
  output logic [C_DEPTH_LOG2:0]     frames_stored,
  output logic                      drop_pulse
`ifdef NF_10G_TX_BUF_STATS_EN
  ,
  output logic [31:0]               tx_frame_count,
  output logic [31:0]               tx_drop_count
`endif
);

  localparam int KW    = C_DATA_WIDTH / 8;
  localparam int EW    = 1 + KW + C_DATA_WIDTH;
  localparam int PW    = C_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << C_DEPTH_LOG2;

  typedef enum logic { WR_WRITE, WR_DROP } wr_state_t;
  typedef enum logic { RD_IDLE, RD_SEND } rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [EW-1:0] mem      [DEPTH];
  logic          last_mem [DEPTH];
  logic [EW-1:0] rd_data;
  logic          rd_vld;

  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, fill;
  logic          full, s_hs, wr_en, commit, frame_open, overflow;

  logic [EW-1:0] head, spare;
  logic          spare_vld, pop, rd_issue, release_frame, space;
  logic [1:0]    occ;

  assign fill          = wr_ptr - rd_ptr;
  assign full          = (fill == PW'(DEPTH));
  assign s_axis_tready = !areset_clk156 && ((wr_state == WR_DROP) || !full);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign wr_en         = s_hs && (wr_state == WR_WRITE);
  assign commit        = wr_en && s_axis_tlast && !s_axis_tuser;
  assign frame_open    = (wr_ptr != commit_ptr);
  // A frame that fills the whole buffer can never be committed, so it must be dropped.
  assign overflow      = (wr_state == WR_WRITE) && full && (frames_stored == '0) && frame_open;

  // Occupancy of the output skid counts the read still in flight from the RAM.
  assign pop           = m_axis_mac_tvalid && m_axis_mac_tready;
  assign occ           = 2'(m_axis_mac_tvalid) + 2'(spare_vld) + 2'(rd_vld);
  assign space         = (occ - 2'(pop)) < 2'd2;
  assign rd_issue      = (rd_state == RD_SEND) && space;
  assign release_frame = rd_issue && last_mem[rd_ptr[C_DEPTH_LOG2-1:0]];

  assign m_axis_mac_tdata = head[C_DATA_WIDTH-1:0];
  assign m_axis_mac_tkeep = head[C_DATA_WIDTH +: KW];
  assign m_axis_mac_tlast = head[EW-1];
  assign m_axis_mac_tuser = 1'b0;

  // NOTE: the RAM has no reset; pointers and rd_vld are reset, so stale contents are never read.
  always_ff @(posedge clk156) begin
    if (wr_en) begin
      mem[wr_ptr[C_DEPTH_LOG2-1:0]]      <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      last_mem[wr_ptr[C_DEPTH_LOG2-1:0]] <= s_axis_tlast;
    end
    if (rd_issue) rd_data <= mem[rd_ptr[C_DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk156) begin
    if (areset_clk156) begin
      wr_state      <= WR_WRITE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      frames_stored <= '0;
      drop_pulse    <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (commit && !release_frame)      frames_stored <= frames_stored + PW'(1);
      else if (release_frame && !commit) frames_stored <= frames_stored - PW'(1);
      case (wr_state)
        WR_WRITE: begin
          if (wr_en) begin
            if (s_axis_tlast && s_axis_tuser) begin
              wr_ptr     <= commit_ptr;
              drop_pulse <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
              if (s_axis_tlast) commit_ptr <= wr_ptr + PW'(1);
            end
          end else if (overflow) begin
            wr_ptr     <= commit_ptr;
            drop_pulse <= 1'b1;
            wr_state   <= WR_DROP;
          end
        end
        WR_DROP: if (s_hs && s_axis_tlast) wr_state <= WR_WRITE;
        default: wr_state <= WR_WRITE;
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (areset_clk156) begin
      rd_state          <= RD_IDLE;
      rd_ptr            <= '0;
      rd_vld            <= 1'b0;
      head              <= '0;
      m_axis_mac_tvalid <= 1'b0;
      spare             <= '0;
      spare_vld         <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
      case (rd_state)
        RD_IDLE:
          if ((frames_stored != '0) && !m_axis_mac_tvalid && !spare_vld && !rd_vld)
            rd_state <= RD_SEND;
        RD_SEND:
          // Stay in SEND when another committed frame is waiting, so frames go back to back.
          if (release_frame && (frames_stored == PW'(1)) && !commit) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
      if (!m_axis_mac_tvalid || pop) begin
        if (spare_vld) begin
          head              <= spare;
          m_axis_mac_tvalid <= 1'b1;
          spare_vld         <= rd_vld;
          if (rd_vld) spare <= rd_data;
        end else if (rd_vld) begin
          head              <= rd_data;
          m_axis_mac_tvalid <= 1'b1;
        end else begin
          m_axis_mac_tvalid <= 1'b0;
        end
      end else if (rd_vld) begin
        spare     <= rd_data;
        spare_vld <= 1'b1;
      end
    end
  end

`ifdef NF_10G_TX_BUF_STATS_EN
  always_ff @(posedge clk156) begin
    if (areset_clk156) begin
      tx_frame_count <= '0;
      tx_drop_count  <= '0;
    end else begin
      if (pop && m_axis_mac_tlast && (tx_frame_count != 32'hFFFF_FFFF))
        tx_frame_count <= tx_frame_count + 32'd1;
      if (drop_pulse && (tx_drop_count != 32'hFFFF_FFFF))
        tx_drop_count <= tx_drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nf_10g_tx_frame_buffer.sv
// Directed self-checking bench for nf_10g_tx_frame_buffer (define NF_10G_TX_BUF_STATS_EN to cover stats).
module tb_nf_10g_tx_frame_buffer;

  logic        clk156 = 1'b0;
  logic        areset_clk156;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [9:0]  frames_stored;
  logic        drop_pulse;
`ifdef NF_10G_TX_BUF_STATS_EN
  logic [31:0] tx_frame_count, tx_drop_count;
`endif

  nf_10g_tx_frame_buffer #(.C_DATA_WIDTH(64), .C_DEPTH_LOG2(9)) dut (
    .clk156(clk156), .areset_clk156(areset_clk156),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_mac_tdata(m_tdata), .m_axis_mac_tkeep(m_tkeep), .m_axis_mac_tvalid(m_tvalid),
    .m_axis_mac_tready(m_tready), .m_axis_mac_tlast(m_tlast), .m_axis_mac_tuser(m_tuser),
    .frames_stored(frames_stored), .drop_pulse(drop_pulse)
`ifdef NF_10G_TX_BUF_STATS_EN
    , .tx_frame_count(tx_frame_count), .tx_drop_count(tx_drop_count)
`endif
  );

  always #5 clk156 = ~clk156;

  int n_checks = 0;
  int n_fail   = 0;
  logic rand_rdy  = 1'b0;
  logic fixed_rdy = 1'b1;

  // Monitor state (written only by the monitor process)
  logic [72:0] cap_q[$];
  int hs_count = 0, gaps = 0, drops = 0, bp_seen = 0, fs_nonzero = 0, tuser_bad = 0;
  int acc_at_drop = -1;
  logic in_frame = 1'b0;

  // Bench-side state (written only by the stimulus process)
  int rd_idx = 0;
  int acc_count = 0;

  always @(posedge clk156) begin
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end

  always @(negedge clk156) begin
    if (areset_clk156) begin
      in_frame <= 1'b0;
    end else begin
      if (m_tvalid && m_tready) begin
        cap_q.push_back({m_tlast, m_tkeep, m_tdata});
        hs_count <= hs_count + 1;
        in_frame <= !m_tlast;
        if (m_tuser) tuser_bad <= tuser_bad + 1;
      end else if (in_frame && !m_tvalid) begin
        gaps <= gaps + 1;
      end
      if (drop_pulse) begin
        drops       <= drops + 1;
        acc_at_drop <= acc_count;
      end
      if (s_tvalid && !s_tready) bp_seen <= bp_seen + 1;
      if (frames_stored != '0) fs_nonzero <= fs_nonzero + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int fid, input int idx);
    logic [31:0] mix;
    mix = 32'(idx * 32'h9E37_79B1) ^ 32'(fid * 32'h0101_0101);
    return {fid[15:0], idx[15:0], mix};
  endfunction

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    logic ok;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20000 && !ok; t++) begin
      @(negedge clk156);
      ok = s_tready;
      @(posedge clk156);
      #1;
    end
    if (ok) acc_count++;
    else check("s_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_frame(input int fid, input int nb, input logic [7:0] lkeep, input logic u,
                            input int gap_at, input int gap_len);
    for (int i = 0; i < nb; i++) begin
      if (i == gap_at) begin
        s_tvalid = 1'b0;
        repeat (gap_len) tick();
      end
      send_beat(beat_data(fid, i), (i == nb - 1) ? lkeep : 8'hFF, i == nb - 1, u && (i == nb - 1));
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet, t;
    quiet = 0; t = 0;
    while (quiet < 4 && t < 20000) begin
      tick();
      t++;
      if (frames_stored == '0 && !m_tvalid) quiet++;
      else quiet = 0;
    end
    check({tag, "_drain"}, 64'(quiet >= 4), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int fid, input int nb, input logic [7:0] lkeep);
    int bad;
    logic [72:0] e;
    bad = 0;
    for (int i = 0; i < nb; i++) begin
      e = {i == nb - 1, (i == nb - 1) ? lkeep : 8'hFF, beat_data(fid, i)};
      if (rd_idx >= cap_q.size()) begin
        bad++;
      end else begin
        if (cap_q[rd_idx] !== e) bad++;
        rd_idx++;
      end
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int lat, g0, d0, f0, b0, h0;
    areset_clk156 = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_tready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tuser", 64'(m_tuser), 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_frames_stored", 64'(frames_stored), 64'd0);
    check("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    areset_clk156 = 1'b0;
    tick();
    check("post_rst_s_tready", 64'(s_tready), 64'd1);
`ifdef NF_10G_TX_BUF_STATS_EN
    check("rst_tx_frame_count", 64'(tx_frame_count), 64'd0);
    check("rst_tx_drop_count", 64'(tx_drop_count), 64'd0);
`endif

    // 1: 64B frame, tready=1, first beat three cycles after tlast
    g0 = gaps;
    send_frame(1, 8, 8'hFF, 1'b0, -1, 0);
    lat = 0;
    while (!m_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd3);
    wait_idle("t1");
    check_frame("t1_frame", 1, 8, 8'hFF);
    check("t1_gaps", 64'(gaps - g0), 64'd0);
    check("t1_tuser", 64'(tuser_bad), 64'd0);

    // 2: 61B frame with a 5-cycle input gap
    g0 = gaps;
    send_frame(2, 8, 8'h1F, 1'b0, 4, 5);
    wait_idle("t2");
    check_frame("t2_frame", 2, 8, 8'h1F);
    check("t2_gaps", 64'(gaps - g0), 64'd0);

    // 3: bad frame (tuser on tlast) is discarded
    d0 = drops; f0 = fs_nonzero; h0 = hs_count;
    send_frame(3, 8, 8'hFF, 1'b1, -1, 0);
    wait_idle("t3");
    check("t3_drop_pulses", 64'(drops - d0), 64'd1);
    check("t3_no_output", 64'(hs_count - h0), 64'd0);
    check("t3_frames_stored_never_set", 64'(fs_nonzero - f0), 64'd0);

    // 4: oversize frame enters DROP after 512 beats, next frame intact
    d0 = drops; acc_count = 0;
    send_frame(4, 600, 8'hFF, 1'b0, -1, 0);
    send_frame(5, 8, 8'hFF, 1'b0, -1, 0);
    wait_idle("t4");
    check("t4_drop_pulses", 64'(drops - d0), 64'd1);
    check("t4_drop_at_beat", 64'(acc_at_drop), 64'd512);
    check_frame("t4_next_frame", 5, 8, 8'hFF);
    check("t4_no_extra", 64'(cap_q.size() - rd_idx), 64'd0);

    // 5: 20 back-to-back 1518B frames against random MAC tready
    g0 = gaps; b0 = bp_seen;
    rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) send_frame(100 + f, 190, 8'h3F, 1'b0, -1, 0);
    wait_idle("t5");
    rand_rdy = 1'b0;
    for (int f = 0; f < 20; f++) check_frame($sformatf("t5_frame%0d", f), 100 + f, 190, 8'h3F);
    check("t5_gaps", 64'(gaps - g0), 64'd0);
    check("t5_backpressure_seen", 64'((bp_seen - b0) > 0), 64'd1);
    check("t5_frames_stored", 64'(frames_stored), 64'd0);

    // 6: reset during beat 4 of 8, then a fresh frame
    h0 = hs_count;
    send_frame(200, 8, 8'hFF, 1'b0, -1, 0);
    for (int t = 0; t < 200 && (hs_count - h0) < 4; t++) tick();
    check("t6_reached_beat4", 64'(hs_count - h0), 64'd4);
    areset_clk156 = 1'b1;
    #1;
    check("t6_rst_s_tready", 64'(s_tready), 64'd0);
    tick();
    check("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_rst_m_tlast", 64'(m_tlast), 64'd0);
    check("t6_rst_m_tdata", m_tdata, 64'd0);
    check("t6_rst_m_tkeep", 64'(m_tkeep), 64'd0);
    check("t6_rst_frames_stored", 64'(frames_stored), 64'd0);
`ifdef NF_10G_TX_BUF_STATS_EN
    check("t6_rst_tx_frame_count", 64'(tx_frame_count), 64'd0);
    check("t6_rst_tx_drop_count", 64'(tx_drop_count), 64'd0);
`endif
    areset_clk156 = 1'b0;
    #1;
    check("t6_post_rst_s_tready", 64'(s_tready), 64'd1);
    rd_idx = cap_q.size();
    send_frame(201, 8, 8'hFF, 1'b0, -1, 0);
    wait_idle("t6");
    check_frame("t6_frame", 201, 8, 8'hFF);
    check("t6_no_extra", 64'(cap_q.size() - rd_idx), 64'd0);
`ifdef NF_10G_TX_BUF_STATS_EN
    check("t6_tx_frame_count", 64'(tx_frame_count), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
